// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
//
// Write-back queue that sits in front of the register file write port. Results
// from long-latency units (load, mul/div) are accepted over a valid/ready
// handshake. They are held in a small in-order FIFO and drained one per cycle
// whenever the single-cycle path is not using the write port. Decode can look up
// two register indices against the results that are still pending, so it can
// forward them before they reach the register file.
//
// Ports
//   i_Clk, i_Rst          clock (rising edge), asynchronous active-high reset
//   i_Valid / o_Ready     producer handshake; o_Ready == !full
//   i_DestReg, i_Result   incoming result (register 0 is accepted and dropped)
//   i_PortBusy            write port taken this cycle; the drain stalls
//   o_RegWrite            registered write strobe (1-cycle latency after a pop)
//   o_WriteReg/Data       registered write index / data (hold when idle)
//   i_LookupReg1/2        forwarding lookup indices (rs / rt)
//   o_Fwd1Hit/Data        youngest pending match for lookup 1 (data 0 on miss)
//   o_Fwd2Hit/Data        youngest pending match for lookup 2 (data 0 on miss)
//   o_Count, o_Empty      occupancy
// -----------------------------------------------------------------------------
module wb_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    input  logic                     i_Valid,
    output logic                     o_Ready,
    input  logic [ADDR_W-1:0]        i_DestReg,
    input  logic [DATA_W-1:0]        i_Result,
    input  logic                     i_PortBusy,
    output logic                     o_RegWrite,
    output logic [ADDR_W-1:0]        o_WriteReg,
    output logic [DATA_W-1:0]        o_WriteData,
    input  logic [ADDR_W-1:0]        i_LookupReg1,
    input  logic [ADDR_W-1:0]        i_LookupReg2,
    output logic                     o_Fwd1Hit,
    output logic [DATA_W-1:0]        o_Fwd1Data,
    output logic                     o_Fwd2Hit,
    output logic [DATA_W-1:0]        o_Fwd2Data,
    output logic [$clog2(DEPTH):0]   o_Count,
    output logic                     o_Empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] regMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];

    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  count;

    logic full;
    logic empty;
    logic doStore;
    logic doPop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign o_Ready = !full;
    assign o_Count = count;
    assign o_Empty = empty;

    // A register-0 result completes the handshake but never occupies a slot.
    assign doStore = i_Valid && !full && (i_DestReg != '0);
    // The pop only sees entries stored on earlier edges, so there is no
    // same-edge bypass from the input to the write outputs.
    assign doPop   = !empty && !i_PortBusy;

    // NOTE: the entry storage has no reset; occupancy is tracked by count and
    // the pointers, so stale contents are never observed and the array can map
    // onto plain flops or distributed RAM without a reset network.
    always_ff @(posedge i_Clk) begin
        if (doStore) begin
            regMem[tailPtr]  <= i_DestReg;
            dataMem[tailPtr] <= i_Result;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            headPtr     <= '0;
            tailPtr     <= '0;
            count       <= '0;
            o_RegWrite  <= 1'b0;
            o_WriteReg  <= '0;
            o_WriteData <= '0;
        end else begin
            if (doStore) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end

            o_RegWrite <= doPop;
            if (doPop) begin
                o_WriteReg  <= regMem[headPtr];
                o_WriteData <= dataMem[headPtr];
                headPtr     <= headPtr + PTR_W'(1);
            end

            case ({doStore, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Forwarding: walk the occupied slots from oldest to youngest so that a
    // later (younger) match overrides an earlier one. The entry already moved
    // to the write outputs has left the queue and is no longer considered.
    always_comb begin
        logic [PTR_W-1:0] idx;
        // NOTE: every output of this block gets a default before the loop, so
        // no path leaves a value unassigned and no latch is inferred.
        idx        = '0;
        o_Fwd1Hit  = 1'b0;
        o_Fwd1Data = '0;
        o_Fwd2Hit  = 1'b0;
        o_Fwd2Data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = headPtr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if ((i_LookupReg1 != '0) && (regMem[idx] == i_LookupReg1)) begin
                    o_Fwd1Hit  = 1'b1;
                    o_Fwd1Data = dataMem[idx];
                end
                if ((i_LookupReg2 != '0) && (regMem[idx] == i_LookupReg2)) begin
                    o_Fwd2Hit  = 1'b1;
                    o_Fwd2Data = dataMem[idx];
                end
            end
        end
    end

endmodule
